// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the load/store unit.
//   XLEN         : default data/address width
//   lsu_state_t  : LSU memory-op FSM states (IDLE, REQ, WAIT, DONE)
//   F3_*         : funct3 load/store size and sign codes
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: data-memory request/response bundle between the LSU and memory.
//   dmem_req_valid/ready : request handshake (LSU -> memory)
//   dmem_req_we          : 1 = store, 0 = load
//   dmem_req_addr        : word-aligned byte address
//   dmem_req_wdata/be    : lane-replicated store data and byte enables
//   dmem_rsp_valid/rdata : load response (memory -> LSU)
// Modports: master = LSU side, slave = memory side.
interface lsu_mem_if #(
    parameter int XLEN = riscv_pkg::XLEN
) ();

    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_req_we;
    logic [XLEN-1:0] dmem_req_addr;
    logic [XLEN-1:0] dmem_req_wdata;
    logic [3:0]      dmem_req_be;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid,
        input  dmem_req_ready,
        output dmem_req_we,
        output dmem_req_addr,
        output dmem_req_wdata,
        output dmem_req_be,
        input  dmem_rsp_valid,
        input  dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid,
        output dmem_req_ready,
        input  dmem_req_we,
        input  dmem_req_addr,
        input  dmem_req_wdata,
        input  dmem_req_be,
        output dmem_rsp_valid,
        output dmem_rsp_rdata
    );

endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: selects the byte/halfword of a load response at the given
// byte offset and sign/zero-extends it according to funct3.
//   rdata  : raw response word
//   offset : byte offset of the access within the word
//   funct3 : load size/sign code
//   ext    : extended load result
module lsu_load_ext
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   ext = {{(XLEN-16){1'b0}}, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: MEM-stage load/store unit. Converts one load/store per
// instruction into a single data-memory transaction, stalls the pipeline
// until it completes, and returns the extended load result.
//   clk, rst             : rising-edge clock, async active-high reset
//   EXMEM_valid          : a real instruction occupies MEM
//   MemReadM / MemWriteM : load / store (store wins if both)
//   Funct3M              : size and sign code
//   ALUResultM           : byte address
//   WriteDataM           : right-aligned store data
//   dmem                 : data-memory request/response bundle (master)
//   ReadDataM            : registered, extended load result
//   StallM               : freezes IF/ID/EX and EX/MEM while the op runs
//   MemFaultM            : misaligned or illegal-size access (IDLE only)
module lsu_mem
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EXMEM_valid,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [2:0]       Funct3M,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  WriteDataM,
    lsu_mem_if.master        dmem,
    output logic [XLEN-1:0]  ReadDataM,
    output logic             StallM,
    output logic             MemFaultM
);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;

    logic            active;
    logic            illegal_f3;
    logic            misaligned;
    logic            start;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;
    logic [XLEN-1:0] load_ext;

    // Decode of the instruction currently presented in IDLE. Funct3M[1:0]
    // selects the size; Funct3M[2] only selects zero-extension for loads.
    always_comb begin
        active     = (state_q == IDLE) && EXMEM_valid && (MemReadM || MemWriteM);
        illegal_f3 = (Funct3M == 3'b011) || (Funct3M[2:1] == 2'b11);
        case (Funct3M[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ALUResultM[1:0];
                wdata_calc = {(XLEN/8){WriteDataM[7:0]}};
                misaligned = 1'b0;
            end
            2'b01: begin
                be_calc    = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_calc = {(XLEN/16){WriteDataM[15:0]}};
                misaligned = ALUResultM[0];
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = WriteDataM;
                misaligned = |ALUResultM[1:0];
            end
        endcase
        MemFaultM = active && (illegal_f3 || misaligned);
        start     = active && !illegal_f3 && !misaligned;
    end

    lsu_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata  (dmem.dmem_rsp_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .ext    (load_ext)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = REQ;
                    addr_d   = {ALUResultM[XLEN-1:2], 2'b00};
                    we_d     = MemWriteM;
                    be_d     = be_calc;
                    wdata_d  = wdata_calc;
                    funct3_d = Funct3M;
                    off_d    = ALUResultM[1:0];
                end
            end
            REQ: begin
                if (dmem.dmem_req_ready) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem.dmem_rsp_valid) begin
                    state_d = DONE;
                    rdata_d = load_ext;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        StallM = start || (state_q == REQ) || (state_q == WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            funct3_q <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
        end
    end

    assign dmem.dmem_req_valid = (state_q == REQ);
    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_wdata = wdata_q;
    assign dmem.dmem_req_be    = be_q;
    assign ReadDataM           = rdata_q;

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 The block SHALL take parameter XLEN, default riscv_pkg::XLEN (32), as the data/address width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 The block SHALL have port EXMEM_valid, input, 1, meaning a real instruction is in MEM.
REQ-005 The block SHALL have port MemReadM, input, 1, meaning a load.
REQ-006 The block SHALL have port MemWriteM, input, 1, meaning a store.
REQ-007 The block SHALL have port Funct3M, input, 3, the load/store size and sign code.
REQ-008 The block SHALL have port ALUResultM, input, XLEN, the byte address.
REQ-009 The block SHALL have port WriteDataM, input, XLEN, the store data, right-aligned.
REQ-010 The block SHALL have the following data-memory request ports:
- dmem_req_valid, output, 1.
- dmem_req_ready, input, 1.
- dmem_req_we, output, 1.
- dmem_req_addr, output, XLEN, word-aligned with bits [1:0]=0.
- dmem_req_wdata, output, XLEN.
- dmem_req_be, output, 4.
REQ-011 The block SHALL have the following data-memory response ports:
- dmem_rsp_valid, input, 1.
- dmem_rsp_rdata, input, XLEN.
REQ-012 The block SHALL have port ReadDataM, output, XLEN, the extended load result.
REQ-013 The block SHALL have port StallM, output, 1, which freezes IF/ID/EX and the EX/MEM register.
REQ-014 The block SHALL have port MemFaultM, output, 1, a misaligned or illegal-size access flag.

Function
REQ-015 An op starts when the FSM is in IDLE, EXMEM_valid=1, (MemReadM|MemWriteM)=1 and there is no fault.
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-017 The FSM SHALL make these transitions:
- IDLE->REQ on start.
- REQ->DONE when dmem_req_ready=1 and the op is a store.
- REQ->WAIT when dmem_req_ready=1 and the op is a load.
- WAIT->DONE when dmem_rsp_valid=1.
- DONE->IDLE unconditionally.
REQ-018 On IDLE->REQ the block SHALL latch address, we, be, wdata, Funct3M and the byte offset; dmem_req_* SHALL be driven only from these latched values.
REQ-019 dmem_req_valid SHALL be 1 exactly in REQ, and the request fields SHALL stay stable until dmem_req_ready is sampled high.
REQ-020 StallM SHALL be computed combinationally as (IDLE & start) | REQ | WAIT; it SHALL be 0 in DONE so the instruction retires at that edge.
REQ-021 Minimum latency SHALL be 3 cycles per memory op (IDLE, REQ, DONE) for a store with ready=1, and 4 cycles for a load with a next-cycle response.
REQ-022 Each Funct3M value SHALL drive the byte enables, write data and required alignment as follows:
- SB (000): be = 0001<<addr[1:0], wdata = byte replicated x4, any alignment.
- SH (001): be = 0011<<{addr[1],1'b0}, wdata = halfword replicated x2, requires addr[0]=0.
- SW (010): be = 1111, requires addr[1:0]=0.
REQ-023 On WAIT->DONE the block SHALL register ReadDataM by selecting the byte/half at the latched offset from dmem_rsp_rdata, then extending as follows:
- LB/LH sign-extend.
- LBU (100) and LHU (101) zero-extend.
- LW passes through.
REQ-024 ReadDataM SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-025 MemFaultM SHALL be asserted combinationally in IDLE when EXMEM_valid=1, a memory op is present, and one of the following holds:
- The access is misaligned per REQ-022 (LH/LHU follow the SH rule, LW the SW rule).
- Funct3M is 011, 110 or 111.
In this case the block SHALL issue no request and SHALL NOT assert StallM.
REQ-026 When EXMEM_valid=0, or when there is no memory op, StallM=0 and MemFaultM=0 and the FSM SHALL stay in IDLE.
REQ-027 dmem_rsp_valid outside WAIT SHALL be ignored.
REQ-028 If MemReadM and MemWriteM are both 1, the block SHALL treat the op as a store.
REQ-029 Inputs changing while in REQ/WAIT/DONE SHALL have no effect, because the FSM samples inputs only in IDLE.

Reset
REQ-030 Asserting rst SHALL immediately drive the FSM to IDLE, dmem_req_valid=0, dmem_req_we=0, dmem_req_be=0, dmem_req_addr/wdata=0 and ReadDataM=0; consequently StallM=0 and MemFaultM=0 unless started in the same cycle after release.
REQ-031 Reset asserted in the middle of REQ or WAIT SHALL abandon the transaction, and any later response SHALL be ignored.

Structure
REQ-032 riscv_pkg SHALL hold the lsu_state_t enum (IDLE, REQ, WAIT, DONE) and the funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-033 The block SHALL contain one combinational sub-module, lsu_load_ext (inputs rdata, offset, funct3; output extended XLEN word), instantiated for REQ-023.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- SW, addr 0x104, wdata 0xDEADBEEF, ready=1 -> dmem_req_addr 0x104, be 1111, we=1, valid high exactly one cycle; StallM high for 2 cycles, then 0.
- LB, addr 0x203, rsp 0x80FF_1234 returned 2 cycles after acceptance -> ReadDataM 0xFFFF_FF80; LBU on the same inputs -> 0x0000_0080.
- SH, addr 0x012, wdata 0x0000_ABCD, ready held low for 3 cycles -> valid, addr 0x010, be 1100 and wdata 0xABCD_ABCD all stable for 4 cycles; StallM high throughout.
- LW at 0x102 -> MemFaultM=1 in the same cycle, dmem_req_valid never rises, StallM=0.
- rst pulsed while in WAIT, then rsp_valid=1 -> FSM in IDLE, ReadDataM=0, response ignored, no stall.
- EXMEM_valid=0 with MemWriteM=1 -> no request, StallM=0, MemFaultM=0.
